// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: step encoding, opcodes, ALU ops.
package proc_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  // Map an instruction opcode to the ALU operation; non-ALU opcodes fall back to ADD.
  function automatic alu_op_t alu_op_of(input logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

  // True for the opcodes that run the three-step A/G sequence.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: modulo-2^WORD add/sub and bitwise and/xor, with zero detect.
module proc_alu
  import proc_pkg::*;
#(
  parameter int WORD = 16
) (
  input  alu_op_t         op,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic [WORD-1:0] result,
  output logic            zero
);

  // Select the operation; carry and borrow fall off the top.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/proc_core.sv
// Parametrised multicycle processor core: shared bus, A/G accumulators, four-step sequencer.
//
// step | meaning
// T0   | idle / fetch: latch IR from din when run=1
// T1   | MV/MVI/MVNZ/NOP complete here; ALU ops load A from Rx
// T2   | ALU ops: G <= A op Ry, update zflag
// T3   | ALU ops: Rx <= G, complete
module proc_core
  import proc_pkg::*;
#(
  parameter int WORD = 16,
  parameter int NREG = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD-1:0]      din,
  input  logic                 run,
  output logic                 done,
  output logic                 busy,
  output logic                 zflag,
  output logic [WORD-1:0]      bus_out,
  output logic [WORD*NREG-1:0] registers,
  output logic [1:0]           step_out
);

  localparam int RSEL = $clog2(NREG);
  localparam int IRW  = 3 + 2 * RSEL;

  step_t            step, step_nxt;
  logic [IRW-1:0]   ir;
  logic [WORD-1:0]  a_reg, g_reg;
  logic [WORD-1:0]  r [NREG];

  logic [2:0]       op;
  logic [RSEL-1:0]  x, y;
  logic [NREG-1:0]  r_sel;
  logic             sel_din, sel_g;
  logic             r_wr, a_ld, g_ld;
  logic [WORD-1:0]  bus;
  logic [WORD-1:0]  alu_result;
  logic             alu_zero;

  assign op = ir[IRW-1 -: 3];
  assign x  = ir[2*RSEL-1:RSEL];
  assign y  = ir[RSEL-1:0];

  proc_alu #(.WORD(WORD)) u_alu (
    .op     (alu_op_of(op)),
    .a      (a_reg),
    .b      (bus),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Sequencer next state and per-step bus select / load enables.
  always_comb begin
    step_nxt = step;
    r_sel    = '0;
    sel_din  = 1'b0;
    sel_g    = 1'b0;
    r_wr     = 1'b0;
    a_ld     = 1'b0;
    g_ld     = 1'b0;
    done     = 1'b0;
    case (step)
      T0: if (run) step_nxt = T1;
      T1: begin
        if (is_alu_op(op)) begin
          r_sel[x] = 1'b1;
          a_ld     = 1'b1;
          step_nxt = T2;
        end else begin
          case (op)
            OP_MV: begin
              r_sel[y] = 1'b1;
              r_wr     = 1'b1;
            end
            OP_MVI: begin
              sel_din = 1'b1;
              r_wr    = 1'b1;
            end
            OP_MVNZ: begin
              r_sel[y] = 1'b1;
              r_wr     = ~zflag;
            end
            default: ;
          endcase
          done     = 1'b1;
          step_nxt = T0;
        end
      end
      T2: begin
        r_sel[y] = 1'b1;
        g_ld     = 1'b1;
        step_nxt = T3;
      end
      T3: begin
        sel_g    = 1'b1;
        r_wr     = 1'b1;
        done     = 1'b1;
        step_nxt = T0;
      end
      default: step_nxt = T0;
    endcase
  end

  // OR-combined bus mux; zero when no source is selected.
  always_comb begin
    bus = '0;
    if (sel_din) bus = bus | din;
    if (sel_g)   bus = bus | g_reg;
    for (int i = 0; i < NREG; i++) begin
      if (r_sel[i]) bus = bus | r[i];
    end
  end

  // State, IR, accumulators, flag and register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step  <= T0;
      ir    <= '0;
      a_reg <= '0;
      g_reg <= '0;
      zflag <= 1'b1;
      for (int i = 0; i < NREG; i++) r[i] <= '0;
    end else begin
      step <= step_nxt;
      if (step == T0 && run) ir <= din[IRW-1:0];
      if (a_ld) a_reg <= bus;
      if (g_ld) begin
        g_reg <= alu_result;
        zflag <= alu_zero;
      end
      if (r_wr) r[x] <= bus;
    end
  end

  // At most one bus driver per cycle.
  assert property (@(posedge clk) disable iff (reset) $onehot0({sel_g, sel_din, r_sel}));

  for (genvar gi = 0; gi < NREG; gi++) begin : g_regs_out
    assign registers[gi*WORD +: WORD] = r[gi];
  end

  assign bus_out  = bus;
  assign busy     = (step != T0);
  assign step_out = step;

endmodule
